// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
// Fetches one scanline's worth of sprite pixels from the 3-bit pixel memory.
// The pixel memory has a one-cycle registered read. Opaque, on-screen pixels
// are written into the line buffer.
// Optional feature: define SPRITE_HFLIP_EN to add the hflip input. With hflip
// high, the sprite row is read in mirrored column order.

module sprite_line_fetcher #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int ADDR_W      = 11,
    parameter int PIX_W       = 3,
    parameter int LINE_W      = 640,
    parameter int TRANSPARENT = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [9:0]        scanline,
    input  logic [9:0]        spr_x,
    input  logic [9:0]        spr_y,
    input  logic [ADDR_W-1:0] spr_base,
`ifdef SPRITE_HFLIP_EN
    input  logic              hflip,
`endif
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              lb_we,
    output logic [9:0]        lb_addr,
    output logic [PIX_W-1:0]  lb_data
);

    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        scanline_q, scanline_d;
    logic [9:0]        spr_x_q, spr_x_d;
    logic [9:0]        spr_y_q, spr_y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [9:0]        row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              hit_q, hit_d;
    logic              ret_valid_q, ret_valid_d;
    logic [10:0]       ret_x_q, ret_x_d;
`ifdef SPRITE_HFLIP_EN
    logic              hflip_q, hflip_d;
`endif

    logic [9:0]        row_calc;
    logic [COL_W-1:0]  rd_col;

    // State and datapath registers. Reset also empties the read-return stage,
    // so an aborted request cannot leave a pending line-buffer write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            scanline_q  <= '0;
            spr_x_q     <= '0;
            spr_y_q     <= '0;
            base_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            hit_q       <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_x_q     <= '0;
`ifdef SPRITE_HFLIP_EN
            hflip_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            scanline_q  <= scanline_d;
            spr_x_q     <= spr_x_d;
            spr_y_q     <= spr_y_d;
            base_q      <= base_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hit_q       <= hit_d;
            ret_valid_q <= ret_valid_d;
            ret_x_q     <= ret_x_d;
`ifdef SPRITE_HFLIP_EN
            hflip_q     <= hflip_d;
`endif
        end
    end

    // Next-state logic and request sequencing. Each FETCH cycle issues one
    // read and arms the return stage, which sees the data one cycle later.
    always_comb begin
        state_d     = state_q;
        scanline_d  = scanline_q;
        spr_x_d     = spr_x_q;
        spr_y_d     = spr_y_q;
        base_d      = base_q;
        row_d       = row_q;
        col_d       = col_q;
        hit_d       = hit_q;
        ret_valid_d = 1'b0;
        ret_x_d     = ret_x_q;
`ifdef SPRITE_HFLIP_EN
        hflip_d     = hflip_q;
`endif
        row_calc    = scanline_q - spr_y_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    scanline_d = scanline;
                    spr_x_d    = spr_x;
                    spr_y_d    = spr_y;
                    base_d     = spr_base;
`ifdef SPRITE_HFLIP_EN
                    hflip_d    = hflip;
`endif
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (row_calc >= 10'(SPR_H)) begin
                    hit_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    hit_d   = 1'b1;
                    row_d   = row_calc;
                    col_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ret_valid_d = 1'b1;
                ret_x_d     = 11'(spr_x_q) + 11'(col_q);
                col_d       = col_q + 1'b1;
                if (col_q == COL_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode. The read address is driven only while fetching, and the
    // line-buffer port is driven only while a read is returning.
    always_comb begin
`ifdef SPRITE_HFLIP_EN
        rd_col = hflip_q ? (COL_LAST - col_q) : col_q;
`else
        rd_col = col_q;
`endif
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        hit      = (state_q == S_DONE) && hit_q;
        rom_addr = '0;
        if (state_q == S_FETCH) begin
            rom_addr = base_q + (ADDR_W'(row_q) * ADDR_W'(SPR_W)) + ADDR_W'(rd_col);
        end
        lb_we   = ret_valid_q && (rom_data != PIX_W'(TRANSPARENT)) && (ret_x_q < 11'(LINE_W));
        lb_addr = ret_valid_q ? ret_x_q[9:0] : '0;
        lb_data = ret_valid_q ? rom_data : '0;
    end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb_sprite_line_fetcher
// Scoreboard bench for sprite_line_fetcher. The stimulus pushes expected
// line-buffer writes and done pulses into queues. A monitor pops from those
// queues and compares them against the DUT outputs on every falling edge.
// Define SPRITE_HFLIP_EN to also exercise the mirrored read order.

module tb_sprite_line_fetcher;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  scanline = '0;
    logic [9:0]  spr_x = '0;
    logic [9:0]  spr_y = '0;
    logic [10:0] spr_base = '0;
`ifdef SPRITE_HFLIP_EN
    logic        hflip = 1'b0;
`endif
    logic        busy, done, hit, lb_we;
    logic [10:0] rom_addr;
    logic [2:0]  rom_data;
    logic [9:0]  lb_addr;
    logic [2:0]  lb_data;

    logic [2:0]  mem [0:2047];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int cyc;
        int hit;
    } dn_t;

    wr_t wrQ[$];
    dn_t dnQ[$];
    wr_t monW;
    dn_t monD;

    sprite_line_fetcher dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .scanline (scanline),
        .spr_x    (spr_x),
        .spr_y    (spr_y),
        .spr_base (spr_base),
`ifdef SPRITE_HFLIP_EN
        .hflip    (hflip),
`endif
        .busy     (busy),
        .done     (done),
        .hit      (hit),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .lb_we    (lb_we),
        .lb_addr  (lb_addr),
        .lb_data  (lb_data)
    );

    // Free-running clock
    always #5 Clk = ~Clk;

    // Pixel memory with a one-cycle registered read
    always @(posedge Clk) rom_data <= mem[rom_addr];

    // Cycle counter; the value seen at a falling edge numbers that cycle
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every write or done pulse must match the head of its queue
    always @(negedge Clk) begin
        if (lb_we === 1'b1) begin
            if (wrQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWrite: got addr=%0d data=%0d at cycle %0d, expected no write",
                         lb_addr, lb_data, cyc);
            end else begin
                monW = wrQ.pop_front();
                checkOutput("wrCycle", cyc, monW.cyc);
                checkOutput("wrAddr", int'(lb_addr), monW.addr);
                checkOutput("wrData", int'(lb_data), monW.data);
            end
        end
        if (done === 1'b1) begin
            if (dnQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: got done at cycle %0d, expected none", cyc);
            end else begin
                monD = dnQ.pop_front();
                checkOutput("doneCycle", cyc, monD.cyc);
                checkOutput("doneHit", int'(hit), monD.hit);
            end
        end
    end

    // mode 0: every pixel = val; mode 1: even cols 0, odd cols val;
    // mode 2: col0 = 1, col31 = 7, everything else transparent
    task automatic fillRow(input int base, input int row, input int mode, input int val);
        int a;
        int d;
        for (int col = 0; col < 32; col++) begin
            a = (base + row * 32 + col) & 2047;
            case (mode)
                0:       d = val;
                1:       d = (col % 2 == 1) ? val : 0;
                default: d = (col == 0) ? 1 : ((col == 31) ? 7 : 0);
            endcase
            mem[a] = 3'(d);
        end
    endtask

    task automatic pushExpect(input int c0, input int sx, input int row, input int base,
                              input int hf, input int nCols, input int withDone);
        int src;
        int d;
        int x;
        for (int col = 0; col < nCols; col++) begin
            src = (hf != 0) ? 31 - col : col;
            d   = int'(mem[(base + row * 32 + src) & 2047]);
            x   = sx + col;
            if (d != 0 && x < 640) wrQ.push_back('{c0 + 3 + col, x, d});
        end
        if (withDone != 0) dnQ.push_back('{c0 + 35, 1});
    endtask

    task automatic drainCheck();
        checkOutput("wrQueueDrained", wrQ.size(), 0);
        checkOutput("doneQueueDrained", dnQ.size(), 0);
        wrQ.delete();
        dnQ.delete();
    endtask

    // One full request. Busy is checked every cycle, and rom_addr is checked
    // on each issue cycle. With extra set, start is also pulsed during FETCH
    // and in the done cycle, and both pulses must be ignored.
    task automatic applyStimulus(input int sx, input int sy, input int sl, input int base,
                                 input int hf, input int extra, input int chkAddr);
        int row;
        int isHit;
        int doneK;
        int c0;
        int src;
        row   = (sl - sy) & 1023;
        isHit = (row < 32) ? 1 : 0;
        doneK = (isHit != 0) ? 35 : 2;
        @(negedge Clk);
        c0 = cyc;
        if (isHit != 0) pushExpect(c0, sx, row, base, hf, 32, 1);
        else dnQ.push_back('{c0 + 2, 0});
        spr_x    = 10'(sx);
        spr_y    = 10'(sy);
        scanline = 10'(sl);
        spr_base = 11'(base);
`ifdef SPRITE_HFLIP_EN
        hflip    = (hf != 0);
`endif
        for (int k = 0; k < 40; k++) begin
            start = (k == 0) || ((extra != 0) && (k == 5 || k == 35));
            checkOutput("busy", int'(busy), (k >= 1 && k <= doneK) ? 1 : 0);
            if (chkAddr != 0 && isHit != 0 && k >= 2 && k <= 33) begin
                src = (hf != 0) ? 31 - (k - 2) : (k - 2);
                checkOutput("romAddr", int'(rom_addr), (base + row * 32 + src) & 2047);
            end
            @(negedge Clk);
        end
        start = 1'b0;
        drainCheck();
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int c0;
        for (int i = 0; i < 2048; i++) mem[i] = 3'd0;

        // Reset state
        repeat (2) @(negedge Clk);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstHit", int'(hit), 0);
        checkOutput("rstLbWe", int'(lb_we), 0);
        checkOutput("rstRomAddr", int'(rom_addr), 0);
        checkOutput("rstLbAddr", int'(lb_addr), 0);
        checkOutput("rstLbData", int'(lb_data), 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        $display("[TB] miss: scanline above sprite");
        applyStimulus(100, 100, 50, 0, 0, 0, 0);

        $display("[TB] miss: row 32 just below sprite");
        applyStimulus(100, 100, 132, 0, 0, 0, 0);

        $display("[TB] hit: row 2, all pixels 5, extra start pulses");
        fillRow(0, 2, 0, 5);
        applyStimulus(100, 10, 12, 0, 0, 1, 1);

        $display("[TB] transparency with address wrap");
        fillRow(11'h7F0, 3, 1, 3);
        applyStimulus(300, 200, 203, 11'h7F0, 0, 0, 1);

        $display("[TB] right clip on last sprite row");
        fillRow(11'h400, 31, 0, 6);
        applyStimulus(620, 40, 71, 11'h400, 0, 0, 1);

        $display("[TB] reset mid-fetch");
        fillRow(0, 2, 0, 5);
        @(negedge Clk);
        c0 = cyc;
        pushExpect(c0, 100, 2, 0, 0, 7, 0);
        spr_x    = 10'd100;
        spr_y    = 10'd10;
        scanline = 10'd12;
        spr_base = 11'd0;
`ifdef SPRITE_HFLIP_EN
        hflip    = 1'b0;
`endif
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (8) @(negedge Clk);
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortLbWe", int'(lb_we), 0);
        checkOutput("abortDone", int'(done), 0);
        repeat (40) @(negedge Clk);
        checkOutput("abortIdleBusy", int'(busy), 0);
        drainCheck();
        Reset_n = 1'b1;
        @(negedge Clk);
        applyStimulus(100, 10, 12, 0, 0, 0, 1);

`ifdef SPRITE_HFLIP_EN
        $display("[TB] horizontal flip");
        fillRow(11'h100, 5, 2, 0);
        applyStimulus(200, 20, 25, 11'h100, 1, 0, 1);
`endif

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
